// File: rtl/starfield_ctrl.sv
// Starfield layer sequencer: per-layer speed enables, frame-synchronous config apply,
// priority brightness select with global fade. Fade FSM built only with STARFIELD_CTRL_FADE_EN.
module starfield_ctrl #(
  parameter int NLAYERS     = 3,
  parameter int FADE_FRAMES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   frame_start,
  input  logic                   video_enable,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [1:0]             cfg_layer,
  input  logic [4:0]             cfg_speed,
  input  logic                   cfg_reseed,
  input  logic [1:0]             fade_req,
  output logic                   fade_busy,
  input  logic [NLAYERS-1:0]     layer_on,
  input  logic [8*NLAYERS-1:0]   layer_star,
  output logic [NLAYERS-1:0]     sf_en,
  output logic [NLAYERS-1:0]     sf_rst,
  output logic [3:0]             starlight
);

  logic [4:0]         r_speed [NLAYERS];
  logic [3:0]         r_acc   [NLAYERS];
  logic [5:0]         w_sum   [NLAYERS];
  logic [NLAYERS-1:0] r_sf_en;
  logic [NLAYERS-1:0] r_sf_rst;
  logic               r_cfg_ready;
  logic [1:0]         r_pend_layer;
  logic [4:0]         r_pend_speed;
  logic               r_pend_reseed;
  logic               w_xfer;
  logic               w_apply;
  logic [4:0]         w_level;
  logic [3:0]         w_raw;
  logic               w_found;
  logic [8:0]         w_prod;
  logic [3:0]         r_starlight;

  assign w_xfer  = cfg_valid && r_cfg_ready;
  // A pending config exists exactly while cfg_ready is low.
  assign w_apply = frame_start && !r_cfg_ready;

  always_comb begin
    for (int unsigned i = 0; i < NLAYERS; i++) begin
      w_sum[i] = {2'b00, r_acc[i]} + {1'b0, r_speed[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NLAYERS; i++) begin
        r_speed[i] <= 5'd16;
        r_acc[i]   <= '0;
      end
      r_sf_en       <= '0;
      r_sf_rst      <= '1;
      r_cfg_ready   <= 1'b1;
      r_pend_layer  <= '0;
      r_pend_speed  <= '0;
      r_pend_reseed <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NLAYERS; i++) begin
        if (r_sf_rst[i]) begin
          r_acc[i]   <= '0;
          r_sf_en[i] <= 1'b0;
        end else begin
          r_acc[i]   <= w_sum[i][3:0];
          r_sf_en[i] <= (w_sum[i] >= 6'd16);
        end
        // Out-of-range layer indices match no i and are silently dropped.
        r_sf_rst[i] <= w_apply && r_pend_reseed && (r_pend_layer == 2'(i));
        if (w_apply && (r_pend_layer == 2'(i))) begin
          r_speed[i] <= r_pend_speed;
        end
      end
      if (w_xfer) begin
        r_cfg_ready   <= 1'b0;
        r_pend_layer  <= cfg_layer;
        r_pend_speed  <= (cfg_speed > 5'd16) ? 5'd16 : cfg_speed;
        r_pend_reseed <= cfg_reseed;
      end else if (w_apply) begin
        r_cfg_ready <= 1'b1;
      end
    end
  end

`ifdef STARFIELD_CTRL_FADE_EN
  localparam logic [1:0] ST_ON       = 2'd0;
  localparam logic [1:0] ST_OFF      = 2'd1;
  localparam logic [1:0] ST_FADE_IN  = 2'd2;
  localparam logic [1:0] ST_FADE_OUT = 2'd3;

  logic [1:0] r_state;
  logic [4:0] r_level;
  logic [7:0] r_fcnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_ON;
      r_level <= 5'd16;
      r_fcnt  <= '0;
    end else if (fade_req == 2'b10 && (r_state == ST_ON || r_state == ST_FADE_IN)) begin
      r_state <= ST_FADE_OUT;
      r_fcnt  <= '0;
    end else if (fade_req == 2'b01 && (r_state == ST_OFF || r_state == ST_FADE_OUT)) begin
      r_state <= ST_FADE_IN;
      r_fcnt  <= '0;
    end else if (frame_start && (r_state == ST_FADE_IN || r_state == ST_FADE_OUT)) begin
      if (r_fcnt == 8'(FADE_FRAMES - 1)) begin
        r_fcnt <= '0;
        if (r_state == ST_FADE_IN) begin
          r_level <= r_level + 5'd1;
          if (r_level == 5'd15) r_state <= ST_ON;
        end else begin
          r_level <= r_level - 5'd1;
          if (r_level == 5'd1) r_state <= ST_OFF;
        end
      end else begin
        r_fcnt <= r_fcnt + 8'd1;
      end
    end
  end

  assign w_level   = r_level;
  assign fade_busy = (r_state == ST_FADE_IN) || (r_state == ST_FADE_OUT);
`else
  logic w_unused_fade_req;
  assign w_unused_fade_req = ^fade_req;
  assign w_level   = 5'd16;
  assign fade_busy = 1'b0;
`endif

  always_comb begin
    w_raw   = '0;
    w_found = 1'b0;
    for (int unsigned i = 0; i < NLAYERS; i++) begin
      if (layer_on[i] && !w_found) begin
        w_raw   = layer_star[8*i+4 +: 4];
        w_found = 1'b1;
      end
    end
    w_prod = {5'b00000, w_raw} * {4'b0000, w_level};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_starlight <= '0;
    end else begin
      r_starlight <= video_enable ? w_prod[7:4] : '0;
    end
  end

  assign cfg_ready = r_cfg_ready;
  assign sf_en     = r_sf_en;
  assign sf_rst    = r_sf_rst;
  assign starlight = r_starlight;

endmodule
